gf180mcu_fd_sc_mcu7t5v0__pgate_seq: RTL and testbench

Power-gating sequencer for one switchable power domain in the 7-track 5V cell set. It controls the header switch groups, the isolation and the retention save/restore strobes, in a fixed order and under a level request/acknowledge handshake. The block sits in the always-on domain, next to the well-tap and endcap rows of the gated region. It is synthesizable RTL built from the library's flop and gate cells.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__pgate_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__pgate_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pgate_seq.sv
// Power-gating sequencer for one switchable power domain.
//
// On a sleep request it isolates the domain outputs, pulses the retention
// save strobe, then switches the header groups off one at a time. On a wake
// request it switches the groups back on one at a time, waits for the
// gated rail to report power-good, pulses the retention restore strobe and
// finally drops isolation. Each sequence runs to completion once started.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RN         asynchronous active-low reset
//   VDD, VSS   always-on supply and ground (pass-through only)
//   SLEEP_REQ  level request, 1 = domain off, 0 = domain on
//   SLEEP_ACK  follows SLEEP_REQ once the requested state is reached
//   PGOOD      asynchronous power-good from the gated rail
//   SWEN       header switch-group enables, 1 = conducting
//   ISO        isolation clamp enable
//   SAVE       retention save strobe
//   RESTORE    retention restore strobe
//   ERR        sticky power-good timeout flag
module gf180mcu_fd_sc_mcu7t5v0__pgate_seq #(
    parameter int NSW      = 4,
    parameter int STEP_CYC = 8,
    parameter int SAVE_CYC = 2,
    parameter int TO_CYC   = 256
) (
    input  logic           CLK,
    input  logic           RN,
    inout  wire            VDD,
    inout  wire            VSS,
    input  logic           SLEEP_REQ,
    output logic           SLEEP_ACK,
    input  logic           PGOOD,
    output logic [NSW-1:0] SWEN,
    output logic           ISO,
    output logic           SAVE,
    output logic           RESTORE,
    output logic           ERR
);

    // One shared down-counter covers the pulse widths, the switch steps and
    // the power-good timeout; it is sized for the largest reload value.
    localparam int MAXC = (TO_CYC > STEP_CYC)
                        ? ((TO_CYC > SAVE_CYC) ? TO_CYC : SAVE_CYC)
                        : ((STEP_CYC > SAVE_CYC) ? STEP_CYC : SAVE_CYC);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] SAVE_LOAD = CW'(SAVE_CYC - 1);
    localparam logic [CW-1:0] TO_LOAD   = CW'(TO_CYC - 1);

    typedef enum logic [3:0] {
        S_ON,
        S_ISO_ON,
        S_SAVE,
        S_SW_OFF,
        S_OFF,
        S_SW_ON,
        S_WAIT_PG,
        S_RESTORE,
        S_ISO_OFF
    } stateType;

    stateType       state;
    stateType       stateNext;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cntNext;
    logic [NSW-1:0] swenNext;
    logic           isoNext;
    logic           saveNext;
    logic           restoreNext;
    logic           ackNext;
    logic           errNext;
    logic           pgMeta;
    logic           pgSync;

    // Two-flop synchronizer for the asynchronous power-good input.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            pgMeta <= 1'b0;
            pgSync <= 1'b0;
        end else begin
            pgMeta <= PGOOD;
            pgSync <= pgMeta;
        end
    end

    // State, counter and every output are registered together so no input
    // can reach an output without passing through a flop.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= S_ON;
            cnt       <= '0;
            SWEN      <= '1;
            ISO       <= 1'b0;
            SAVE      <= 1'b0;
            RESTORE   <= 1'b0;
            SLEEP_ACK <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            SWEN      <= swenNext;
            ISO       <= isoNext;
            SAVE      <= saveNext;
            RESTORE   <= restoreNext;
            SLEEP_ACK <= ackNext;
            ERR       <= errNext;
        end
    end

    // Next-state and next-output logic. The switch enables are used as their
    // own progress marker: sleep shifts a zero in from the top, wake shifts
    // a one in from the bottom, so exactly one bit moves per step.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        swenNext    = SWEN;
        isoNext     = ISO;
        saveNext    = SAVE;
        restoreNext = RESTORE;
        ackNext     = SLEEP_ACK;
        errNext     = ERR;

        case (state)
            S_ON: begin
                if (SLEEP_REQ) begin
                    stateNext = S_ISO_ON;
                    isoNext   = 1'b1;
                end
            end

            S_ISO_ON: begin
                stateNext = S_SAVE;
                saveNext  = 1'b1;
                cntNext   = SAVE_LOAD;
            end

            // The save pulse ends on the same edge the top group switches off.
            S_SAVE: begin
                if (cnt == '0) begin
                    stateNext = S_SW_OFF;
                    saveNext  = 1'b0;
                    swenNext  = SWEN >> 1;
                    cntNext   = STEP_LOAD;
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end

            // Once every group is off, one more step elapses as settle time.
            S_SW_OFF: begin
                if (cnt == '0) begin
                    if (SWEN == '0) begin
                        stateNext = S_OFF;
                        ackNext   = 1'b1;
                    end else begin
                        swenNext = SWEN >> 1;
                        cntNext  = STEP_LOAD;
                    end
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end

            S_OFF: begin
                if (!SLEEP_REQ) begin
                    stateNext = S_SW_ON;
                    swenNext  = NSW'(1);
                    cntNext   = STEP_LOAD;
                end
            end

            S_SW_ON: begin
                if (cnt == '0) begin
                    if (&SWEN) begin
                        stateNext = S_WAIT_PG;
                        cntNext   = TO_LOAD;
                    end else begin
                        swenNext = (SWEN << 1) | NSW'(1);
                        cntNext  = STEP_LOAD;
                    end
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end

            // The timeout only raises a flag; the sequencer keeps waiting so
            // a late power-good still completes the wake-up.
            S_WAIT_PG: begin
                if (pgSync) begin
                    stateNext   = S_RESTORE;
                    restoreNext = 1'b1;
                    cntNext     = SAVE_LOAD;
                end else if (cnt == '0) begin
                    errNext = 1'b1;
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end

            S_RESTORE: begin
                if (cnt == '0) begin
                    stateNext   = S_ISO_OFF;
                    restoreNext = 1'b0;
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end

            S_ISO_OFF: begin
                stateNext = S_ON;
                isoNext   = 1'b0;
                ackNext   = 1'b0;
            end

            default: begin
                stateNext   = S_ON;
                cntNext     = '0;
                swenNext    = '1;
                isoNext     = 1'b0;
                saveNext    = 1'b0;
                restoreNext = 1'b0;
                ackNext     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__pgate_seq.sv
// Testbench for the power-gating sequencer.
//
// A stimulus plan (request and power-good levels per clock edge) is built
// first, partly fixed and partly random. A reference model walks the plan
// and pushes every expected output change, with its edge number, into a
// queue. A monitor pops one entry each time the outputs change and compares
// both the edge and the full output vector. A final directed section
// asserts reset in the middle of a switch-off sequence.
module tb_gf180mcu_fd_sc_mcu7t5v0__pgate_seq;

    localparam int NSW      = 4;
    localparam int STEP_CYC = 8;
    localparam int SAVE_CYC = 2;
    localparam int TO_CYC   = 256;
    localparam int N        = 3500;
    localparam int TAIL     = 400;
    localparam int OW       = NSW + 5;

    localparam logic [OW-1:0] RST_VEC = {5'b00000, {NSW{1'b1}}};

    typedef struct {
        int            cyc;
        logic [OW-1:0] vec;
    } evT;

    logic           CLK;
    logic           RN;
    logic           SLEEP_REQ;
    logic           PGOOD;
    logic           SLEEP_ACK;
    logic [NSW-1:0] SWEN;
    logic           ISO;
    logic           SAVE;
    logic           RESTORE;
    logic           ERR;
    wire            vdd = 1'b1;
    wire            vss = 1'b0;

    wire [OW-1:0] outVec = {SLEEP_ACK, ERR, RESTORE, SAVE, ISO, SWEN};

    int  errCnt = 0;
    int  chkCnt = 0;
    int  cycleNo;
    bit  monEn = 0;
    bit  reqLvl [0:N];
    bit  pgLvl  [0:N];
    evT  expQ [$];

    logic [NSW-1:0] mSwen;
    logic           mIso;
    logic           mSave;
    logic           mRestore;
    logic           mAck;
    logic           mErr;

    gf180mcu_fd_sc_mcu7t5v0__pgate_seq #(
        .NSW      (NSW),
        .STEP_CYC (STEP_CYC),
        .SAVE_CYC (SAVE_CYC),
        .TO_CYC   (TO_CYC)
    ) dut (
        .CLK       (CLK),
        .RN        (RN),
        .VDD       (vdd),
        .VSS       (vss),
        .SLEEP_REQ (SLEEP_REQ),
        .SLEEP_ACK (SLEEP_ACK),
        .PGOOD     (PGOOD),
        .SWEN      (SWEN),
        .ISO       (ISO),
        .SAVE      (SAVE),
        .RESTORE   (RESTORE),
        .ERR       (ERR)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge counter: edge 1 is the first rising edge after reset release.
    always @(posedge CLK or negedge RN) begin
        if (!RN) cycleNo <= 0;
        else     cycleNo <= cycleNo + 1;
    end

    task automatic checkOutput(input string name, input logic [OW-1:0] got,
                               input logic [OW-1:0] need);
        chkCnt++;
        if (got !== need) begin
            errCnt++;
            $display("[TB] FAIL %s: got=%b need=%b (ack,err,rst,save,iso,swen)",
                     name, got, need);
        end
    endtask

    function automatic logic [OW-1:0] modelVec();
        return {mAck, mErr, mRestore, mSave, mIso, mSwen};
    endfunction

    task automatic pushEv(input int cyc);
        evT ev;
        ev.cyc = cyc;
        ev.vec = modelVec();
        expQ.push_back(ev);
    endtask

    // Synchronized power-good as seen by the sequencer at edge e: the level
    // present two edges earlier, zero right after reset.
    function automatic bit pgSeen(input int e);
        if (e < 3) return 1'b0;
        return pgLvl[e - 2];
    endfunction

    // Plan: quiet period, a fixed sleep, a wake with a long power-good
    // outage (timeout), a short request pulse landing inside a switch-off,
    // then random request and power-good levels, then a quiet tail.
    task automatic buildPlan();
        int c;
        int len;
        bit lvl;
        for (int i = 0; i <= N; i++) begin
            reqLvl[i] = 1'b0;
            pgLvl[i]  = 1'b1;
        end
        for (int i = 120; i <= 169; i++) reqLvl[i] = 1'b1;
        for (int i = 150; i <= 599; i++) pgLvl[i]  = 1'b0;
        for (int i = 620; i <= 629; i++) reqLvl[i] = 1'b1;
        c   = 700;
        lvl = 1'b1;
        while (c < N - TAIL) begin
            len = $urandom_range(1, 70);
            for (int j = 0; j < len && c < N - TAIL; j++) begin
                reqLvl[c] = lvl;
                c++;
            end
            lvl = !lvl;
        end
        c = 700;
        while (c < N - TAIL) begin
            c += $urandom_range(60, 400);
            len = $urandom_range(1, 300);
            for (int j = 0; j < len && c < N - TAIL; j++) begin
                pgLvl[c] = 1'b0;
                c++;
            end
        end
    endtask

    // Reference model: a sequence starts at the first edge on which the
    // request level differs from the settled state; event times follow
    // from the step, pulse and timeout lengths.
    task automatic buildModel();
        int  t;
        int  e;
        int  c;
        int  w;
        int  r;
        bit  atOn;
        mSwen    = '1;
        mIso     = 1'b0;
        mSave    = 1'b0;
        mRestore = 1'b0;
        mAck     = 1'b0;
        mErr     = 1'b0;
        t        = 1;
        atOn     = 1'b1;
        while (t <= N) begin
            e = t;
            while (e <= N && reqLvl[e] != atOn) e++;
            if (e > N) break;
            if (atOn) begin
                mIso = 1'b1;
                pushEv(e);
                mSave = 1'b1;
                pushEv(e + 1);
                c = e + 1 + SAVE_CYC;
                for (int i = 0; i < NSW; i++) begin
                    if (i == 0) mSave = 1'b0;
                    mSwen[NSW-1-i] = 1'b0;
                    pushEv(c + i * STEP_CYC);
                end
                c    = e + 1 + SAVE_CYC + NSW * STEP_CYC;
                mAck = 1'b1;
                pushEv(c);
                t    = c + 1;
                atOn = 1'b0;
            end else begin
                for (int i = 0; i < NSW; i++) begin
                    mSwen[i] = 1'b1;
                    pushEv(e + i * STEP_CYC);
                end
                w = e + NSW * STEP_CYC;
                r = w + 1;
                while (r <= N && !pgSeen(r)) r++;
                if (r > w + TO_CYC && !mErr) begin
                    mErr = 1'b1;
                    pushEv(w + TO_CYC);
                end
                mRestore = 1'b1;
                pushEv(r);
                mRestore = 1'b0;
                pushEv(r + SAVE_CYC);
                mIso = 1'b0;
                mAck = 1'b0;
                pushEv(r + SAVE_CYC + 1);
                t    = r + SAVE_CYC + 2;
                atOn = 1'b1;
            end
        end
    endtask

    // Drive the planned levels ahead of each rising edge.
    task automatic applyStimulus();
        for (int c = 1; c <= N; c++) begin
            SLEEP_REQ = reqLvl[c];
            PGOOD     = pgLvl[c];
            @(negedge CLK);
        end
    endtask

    // Monitor: every output change consumes one expected event.
    initial begin
        logic [OW-1:0] prevVec;
        logic [OW-1:0] cur;
        evT            ev;
        prevVec = RST_VEC;
        forever begin
            @(negedge CLK);
            if (monEn) begin
                cur = outVec;
                if (cur !== prevVec) begin
                    chkCnt++;
                    if (expQ.size() == 0) begin
                        errCnt++;
                        $display("[TB] FAIL unexpected-change: got cycle=%0d out=%b, need no change",
                                 cycleNo, cur);
                    end else begin
                        ev = expQ.pop_front();
                        if (ev.cyc != cycleNo || ev.vec !== cur) begin
                            errCnt++;
                            $display("[TB] FAIL event: got cycle=%0d out=%b, need cycle=%0d out=%b",
                                     cycleNo, cur, ev.cyc, ev.vec);
                        end
                    end
                end
                prevVec = cur;
            end
        end
    end

    initial begin
        int             k;
        logic [NSW-1:0] expSwen;
        logic           expSave;

        RN        = 1'b0;
        SLEEP_REQ = 1'b0;
        PGOOD     = 1'b0;
        buildPlan();
        buildModel();
        $display("[TB] %0d expected output events queued", expQ.size());

        repeat (3) @(negedge CLK);
        checkOutput("reset-state", outVec, RST_VEC);
        RN    = 1'b1;
        monEn = 1'b1;
        applyStimulus();
        @(negedge CLK);
        #1;
        monEn = 1'b0;

        chkCnt++;
        if (expQ.size() != 0) begin
            errCnt++;
            $display("[TB] FAIL missing-events: got %0d left over, need 0", expQ.size());
        end

        // Reset in the middle of switch-off must restore the ON values at once.
        @(negedge CLK);
        SLEEP_REQ = 1'b1;
        PGOOD     = 1'b1;
        k         = cycleNo + 1;
        repeat (16) @(negedge CLK);
        expSwen = '1;
        for (int i = 0; i < NSW; i++)
            if (1 + SAVE_CYC + i * STEP_CYC <= 15) expSwen[NSW-1-i] = 1'b0;
        expSave = (15 <= SAVE_CYC);
        checkOutput("mid-sw-off", outVec, {1'b0, mErr, 1'b0, expSave, 1'b1, expSwen});
        #2;
        RN = 1'b0;
        #1;
        checkOutput("async-reset", outVec, RST_VEC);
        @(negedge CLK);
        checkOutput("reset-held", outVec, RST_VEC);
        RN        = 1'b1;
        SLEEP_REQ = 1'b0;
        repeat (20) @(negedge CLK);
        checkOutput("on-after-reset", outVec, RST_VEC);
        $display("[TB] reset test began at edge %0d", k);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
